// File: rtl/hamming_result_scanner.sv
// Post-halt self-check: walks the SECDED result region of data memory, classifies
// each 16-bit codeword as clean / single-error / double-error and reports the counts.
module hamming_result_scanner #(
    parameter int unsigned BASE_ADDR = 30,
    parameter int unsigned NUM_WORDS = 15,
    parameter int unsigned AW        = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          go,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          done,
    output logic [7:0]    clean_cnt,
    output logic [7:0]    single_cnt,
    output logic [7:0]    double_cnt,
    output logic [7:0]    first_bad
);

    localparam int unsigned CW       = 8;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] NO_BAD   = 8'hFF;
    localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] idx;
    logic [CW-1:0] idx_nxt;
    logic [7:0]    lo_q;
    logic [7:0]    lo_nxt;
    logic [CW-1:0] clean_nxt;
    logic [CW-1:0] single_nxt;
    logic [CW-1:0] double_nxt;
    logic [CW-1:0] first_bad_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic          mem_rd_nxt;
    logic          busy_nxt;
    logic          done_nxt;

    logic [15:0] word_c;
    logic        p8c;
    logic        p4c;
    logic        p2c;
    logic        p1c;
    logic [3:0]  syn_c;
    logic        ovp_c;
    logic        is_single_c;
    logic        is_double_c;
    logic        is_clean_c;
    logic        last_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == {CW{1'b1}}) ? c : c + CW'(1);
    endfunction

    // Codeword layout {d11..d5, p8, d4..d2, p4, d1, p2, p1, p16}; high byte arrives in EVAL.
    assign word_c = {mem_rdata, lo_q};
    assign p8c    = ^word_c[15:9];
    assign p4c    = ^{word_c[15:12], word_c[7:5]};
    assign p2c    = ^{word_c[15:14], word_c[11:10], word_c[7:6], word_c[3]};
    assign p1c    = ^{word_c[15], word_c[13], word_c[11], word_c[9], word_c[7], word_c[5], word_c[3]};
    assign syn_c  = {word_c[8] ^ p8c, word_c[4] ^ p4c, word_c[2] ^ p2c, word_c[1] ^ p1c};
    assign ovp_c  = ^word_c;

    // An overall-parity flip with zero syndrome is a p16 error and still correctable.
    assign is_single_c = ovp_c;
    assign is_double_c = !ovp_c && (syn_c != 4'd0);
    assign is_clean_c  = !ovp_c && (syn_c == 4'd0);
    assign last_c      = (idx == LAST_IDX);

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_RD_LO;
            S_RD_LO: state_nxt = S_RD_HI;
            S_RD_HI: state_nxt = S_EVAL;
            S_EVAL:  state_nxt = last_c ? S_DONE : S_RD_LO;
            S_DONE:  if (go) state_nxt = S_RD_LO;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; memory strobes are lined up with the state being entered.
    always_comb begin
        idx_nxt       = idx;
        lo_nxt        = lo_q;
        clean_nxt     = clean_cnt;
        single_nxt    = single_cnt;
        double_nxt    = double_cnt;
        first_bad_nxt = first_bad;
        mem_addr_nxt  = mem_addr;

        case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    idx_nxt       = '0;
                    clean_nxt     = '0;
                    single_nxt    = '0;
                    double_nxt    = '0;
                    first_bad_nxt = NO_BAD;
                end
            end
            S_RD_HI: lo_nxt = mem_rdata;
            S_EVAL: begin
                if (is_single_c) begin
                    single_nxt = sat_inc(single_cnt);
                end else if (is_double_c) begin
                    double_nxt = sat_inc(double_cnt);
                end else begin
                    clean_nxt = sat_inc(clean_cnt);
                end
                if (!is_clean_c && first_bad == NO_BAD) begin
                    first_bad_nxt = idx;
                end
                if (!last_c) begin
                    idx_nxt = idx + CW'(1);
                end
            end
            default: ;
        endcase

        if (state_nxt == S_RD_LO) begin
            mem_addr_nxt = BASE + AW'({idx_nxt, 1'b0});
        end else if (state_nxt == S_RD_HI) begin
            mem_addr_nxt = BASE + AW'({idx, 1'b0}) + AW'(1);
        end

        mem_rd_nxt = (state_nxt == S_RD_LO) || (state_nxt == S_RD_HI);
        busy_nxt   = (state_nxt == S_RD_LO) || (state_nxt == S_RD_HI) || (state_nxt == S_EVAL);
        done_nxt   = (state_nxt == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            idx        <= '0;
            lo_q       <= '0;
            clean_cnt  <= '0;
            single_cnt <= '0;
            double_cnt <= '0;
            first_bad  <= NO_BAD;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            idx        <= idx_nxt;
            lo_q       <= lo_nxt;
            clean_cnt  <= clean_nxt;
            single_cnt <= single_nxt;
            double_cnt <= double_nxt;
            first_bad  <= first_bad_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_rd     <= mem_rd_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule
